data_lsu: RTL and testbench
===========================

// Module: data_lsu
// PURPOSE
//  Load/store unit between the pipeline MEM stage and the word-addressed data memory.
//  Accepts one byte-addressed RISC-V load/store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW).
//  Converts each request into one or two word accesses with byte enables, splitting accesses that cross a word boundary.
//  Returns the sign/zero-extended load data, or a store completion, as a one-cycle response.
// PARAMETERS
//  AW          12  word-address width of data memory (2^AW 32-bit words)
//  MISALIGN_EN 1   1: split word-crossing accesses; 0: word-crossing accesses respond with error, no memory access
// PORTS
//  i_clk      in   1   clock; all state updates on posedge
//  i_rst_n    in   1   asynchronous active-low reset
//  req_valid  in   1   request valid
//  req_ready  out  1   unit can accept request (high only in IDLE)
//  req_we     in   1   1 = store, 0 = load
//  req_funct3 in   3   RISC-V width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   32  byte address; bits [AW+1:0] used, upper bits ignored
//  req_wdata  in   32  store data, right-aligned
//  rsp_valid  out  1   one-cycle response strobe
//  rsp_rdata  out  32  load result (0 for stores and errors)
//  rsp_err    out  1   illegal funct3 or disallowed misalignment; valid with rsp_valid
//  mem_req    out  1   memory access request
//  mem_we     out  1   write enable
//  mem_addr   out  AW  word address
//  mem_wdata  out  32  lane-aligned write data
//  mem_be     out  4   byte enables (lane i = bits [8i+7:8i])
//  mem_rdata  in   32  read word; valid when mem_ack=1
//  mem_ack    in   1   access complete; may assert in the same cycle as mem_req
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_req=0, mem_we=0, mem_be=0.
//  Reset mid-operation abandons the transaction: no response, mem_req deasserts immediately.
//  States: IDLE, ACC0, ACC1, RESP.
//   IDLE: req_ready=1; on req_valid capture we/funct3/addr/wdata -> ACC0; illegal -> RESP with err=1.
//   Illegal: funct3 in {011,110,111}; store with funct3[2]=1; crossing access when MISALIGN_EN=0.
//   ACC0: mem_req=1 to word addr[AW+1:2]; hold all mem_* stable until mem_ack.
//         On ack: latch rdata into lo word; crossing -> ACC1, else -> RESP.
//   ACC1: mem_req=1 to word (addr[AW+1:2]+1) mod 2^AW (wraps); on ack latch hi word -> RESP.
//   RESP: rsp_valid=1 exactly one cycle, rsp_err as decided -> IDLE. Requests not accepted in RESP.
//  Size s = 1/2/4 bytes; off = addr[1:0]; crossing = off+s > 4 (H at off 3; W at off 1..3).
//  Store lanes: 64-bit data = wdata << 8*off, 8-bit mask = ((1<<s)-1) << off;
//   ACC0 uses low 32 bits/low 4 mask bits, ACC1 the high halves. Loads drive mem_be=4'b1111, mem_we=0.
//  Load result: ({hi,lo} >> 8*off) truncated to s bytes, sign-extended if funct3[2]=0 else zero-extended.
//  Latency with same-cycle ack: aligned = 3 cycles from accept to rsp_valid; crossing = 4; error = 2.
//  Stores: rsp_rdata=0, rsp_err=0; response only after final ack (store is committed).
// STRUCTURE
//  Shared package: funct3 encodings (F3_B/H/W/BU/HU), LSU state enum, size-decode function.
//  One combinational sub-module lsu_align: byte-lane shift/mask for stores, extract/extend for loads.
//  data_lsu holds the FSM, captured request registers and lo/hi read buffers.
// TESTING
//  SW 0xDEADBEEF @0x100 then LW @0x100 (ack same cycle) -> mem_addr=0x40, be=1111; rsp_rdata=0xDEADBEEF, 3 cycles.
//  SB 0x80 @0x203; LB @0x203 -> be=1000 on store; rsp_rdata=0xFFFFFF80; LBU -> 0x00000080.
//  SW 0x11223344 @0x102 -> ACC0 word 0x40 be=1100 wdata[31:16]=0x3344; ACC1 word 0x41 be=0011 data 0x1122; LW back = 0x11223344.
//  LH @0x3FFF (AW=12) crossing -> second access wraps to word 0x000; result assembled from both words.
//  funct3=011 load, and SB with funct3=100 -> no mem_req; rsp_valid with rsp_err=1 after 2 cycles.
//  mem_ack delayed 3 cycles with req_valid held -> mem_* stable, req_ready=0; i_rst_n low in ACC1 -> no rsp_valid, IDLE.

Source files
------------

// File: rtl/data_lsu_pkg.sv
// Shared types and helpers for the data load/store unit.
package data_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } lsu_req_t;

    // Access size in bytes (1, 2 or 4) from the width bits of funct3.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned widths exist only for loads.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (!we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    endfunction

endpackage

// File: rtl/data_lsu_if.sv
// Pipeline-side request/response and memory-side access signals of the LSU.
interface data_lsu_if #(parameter int unsigned AW = 12);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    // master: pipeline and memory environment; slave: the LSU itself.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/data_lsu_align.sv
// Byte-lane alignment: store data/mask placement and load extract/extend.
module data_lsu_align
    import data_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [63:0] st_data_c,
    output logic [7:0]  st_mask_c,
    output logic [31:0] ld_data_c
);

    logic [2:0]  size;
    logic [5:0]  sh;
    logic [31:0] ld_raw;

    always_comb begin
        size      = size_bytes(funct3);
        sh        = {1'b0, off, 3'b000};
        st_data_c = 64'(wdata) << sh;
        case (size)
            3'd1:    st_mask_c = 8'h01 << off;
            3'd2:    st_mask_c = 8'h03 << off;
            default: st_mask_c = 8'h0F << off;
        endcase
        // Two-word window shifted down so the addressed byte lands in lane 0.
        ld_raw = 32'({hi_word, lo_word} >> sh);
        case (size)
            3'd1:    ld_data_c = funct3[2] ? {24'b0, ld_raw[7:0]}
                                           : {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'd2:    ld_data_c = funct3[2] ? {16'b0, ld_raw[15:0]}
                                           : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_data_c = ld_raw;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit: one byte-addressed request becomes one or two word accesses.
module data_lsu
    import data_lsu_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input logic       i_clk,
    input logic       i_rst_n,
    data_lsu_if.slave bus
);

    lsu_state_e    state_q, state_d;
    lsu_req_t      req_q, req_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          cross_q, cross_d;
    logic          err_q, err_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_q, hi_d;

    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;

    logic          in_cross;
    logic          in_illegal;
    logic [AW-1:0] word_d;
    logic [63:0]   st_data_c;
    logic [7:0]    st_mask_c;
    logic [31:0]   ld_data_c;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    // Crossing: the access runs past byte 3 of its first word.
    always_comb begin
        in_cross   = ({2'b00, bus.req_addr[1:0]} + {1'b0, size_bytes(bus.req_funct3)}) > 4'd4;
        in_illegal = !funct3_legal(bus.req_we, bus.req_funct3) || (in_cross && !MISALIGN_EN);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cross_d = cross_q;
        err_d   = err_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.we     = bus.req_we;
                    req_d.funct3 = bus.req_funct3;
                    req_d.wdata  = bus.req_wdata;
                    addr_d       = bus.req_addr[AW+1:0];
                    cross_d      = in_cross;
                    err_d        = in_illegal;
                    lo_d         = '0;
                    hi_d         = '0;
                    state_d      = in_illegal ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                if (bus.mem_ack) begin
                    lo_d    = bus.mem_rdata;
                    state_d = cross_q ? ST_ACC1 : ST_RESP;
                end
            end
            ST_ACC1: begin
                if (bus.mem_ack) begin
                    hi_d    = bus.mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    data_lsu_align u_align (
        .funct3    (req_d.funct3),
        .off       (addr_d[1:0]),
        .wdata     (req_d.wdata),
        .lo_word   (lo_d),
        .hi_word   (hi_d),
        .st_data_c (st_data_c),
        .st_mask_c (st_mask_c),
        .ld_data_c (ld_data_c)
    );

    // Outputs follow the next state so they are registered yet aligned with it.
    always_comb begin
        word_d      = addr_d[AW+1:2];
        req_ready_d = (state_d == ST_IDLE);
        mem_req_d   = (state_d == ST_ACC0) || (state_d == ST_ACC1);
        mem_we_d    = mem_req_d && req_d.we;
        mem_addr_d  = (state_d == ST_ACC1) ? word_d + AW'(1) : word_d;
        mem_be_d    = 4'b0000;
        mem_wdata_d = '0;
        if (mem_req_d) begin
            if (!req_d.we) begin
                mem_be_d = 4'b1111;
            end else if (state_d == ST_ACC1) begin
                mem_be_d    = st_mask_c[7:4];
                mem_wdata_d = st_data_c[63:32];
            end else begin
                mem_be_d    = st_mask_c[3:0];
                mem_wdata_d = st_data_c[31:0];
            end
        end
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = rsp_valid_d && err_d;
        rsp_rdata_d = (rsp_valid_d && !req_d.we && !err_d) ? ld_data_c : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            cross_q     <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cross_q     <= cross_d;
            err_q       <= err_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu against a byte-level memory/response model.
module tb_data_lsu;

    localparam int unsigned AW    = 12;
    localparam int unsigned NWORD = 1 << AW;
    localparam int unsigned NBYTE = NWORD * 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic          we;
        logic [31:0]   wdata;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_lsu_if #(.AW(AW)) bus ();

    data_lsu #(.AW(AW), .MISALIGN_EN(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Word memory seen by the DUT, with a programmable ack delay per access.
    logic [31:0] mem [NWORD];
    logic [7:0]  bmem [NBYTE];
    bit          mem_inited = 1'b0;
    int          ack_delay  = 0;
    int          ack_cnt    = 0;

    assign bus.mem_ack   = bus.mem_req && (ack_cnt >= ack_delay);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < int'(NWORD); i++) mem[i] <= (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
            mem_inited <= 1'b1;
        end else if (rst_n && bus.mem_req && bus.mem_ack && bus.mem_we) begin
            for (int l = 0; l < 4; l++)
                if (bus.mem_be[l]) mem[bus.mem_addr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
        end
        if (bus.mem_req && !bus.mem_ack) ack_cnt <= ack_cnt + 1;
        else ack_cnt <= 0;
    end

    int   vectors = 0;
    int   miscompares = 0;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    acc_t acc_log[$];
    int   rsp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected word accesses and response derived from byte-address semantics.
    task automatic push_expect(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int d);
        int s, nacc;
        logic [13:0] a, ba;
        logic [31:0] r;
        acc_t e;
        rsp_t p;
        a = addr[13:0];
        s = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) begin
            p.rdata = 32'h0; p.err = 1'b1; p.lat = 2;
            exp_rsp.push_back(p);
            return;
        end
        nacc = (int'(a[1:0]) + s > 4) ? 2 : 1;
        for (int i = 0; i < nacc; i++) begin
            e.addr = AW'(a[13:2] + 12'(i));
            e.we = we;
            e.be = we ? 4'b0000 : 4'b1111;
            e.wdata = 32'h0;
            if (we)
                for (int k = 0; k < s; k++) begin
                    ba = 14'(a + 14'(k));
                    if (ba[13:2] == e.addr) begin
                        e.be[ba[1:0]] = 1'b1;
                        e.wdata[8*ba[1:0] +: 8] = wd[8*k +: 8];
                    end
                end
            exp_acc.push_back(e);
        end
        r = 32'h0;
        for (int k = 0; k < s; k++) begin
            ba = 14'(a + 14'(k));
            if (we) bmem[ba] = wd[8*k +: 8];
            else r[8*k +: 8] = bmem[ba];
        end
        if (!we && !f3[2] && s == 1) r = {{24{r[7]}}, r[7:0]};
        if (!we && !f3[2] && s == 2) r = {{16{r[15]}}, r[15:0]};
        p.rdata = we ? 32'h0 : r;
        p.err = 1'b0;
        p.lat = 2 + nacc * (1 + d);
        exp_rsp.push_back(p);
    endtask

    // Compare process: handshake, access stream, hold stability and responses.
    bit   busy = 1'b0;
    bit   pend = 1'b0;
    acc_t prev_a, cur_a, e_a;
    rsp_t e_r;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic [31:0] lm;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            pend = 1'b0;
        end else begin
            cyc++;
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            cur_a.addr = bus.mem_addr; cur_a.be = bus.mem_be;
            cur_a.we = bus.mem_we; cur_a.wdata = bus.mem_wdata;
            if (pend) begin
                chk("hold_req", 32'(bus.mem_req), 32'h1);
                chk("hold_addr", 32'(cur_a.addr), 32'(prev_a.addr));
                chk("hold_be", 32'(cur_a.be), 32'(prev_a.be));
                chk("hold_we", 32'(cur_a.we), 32'(prev_a.we));
                chk("hold_wdata", cur_a.wdata, prev_a.wdata);
            end
            if (bus.mem_req && bus.mem_ack) begin
                acc_log.push_back(cur_a);
                if (exp_acc.size() == 0) chk("acc_unexpected", 32'(exp_acc.size()), 32'h1);
                else begin
                    e_a = exp_acc.pop_front();
                    chk("acc_addr", 32'(cur_a.addr), 32'(e_a.addr));
                    chk("acc_be", 32'(cur_a.be), 32'(e_a.be));
                    chk("acc_we", 32'(cur_a.we), 32'(e_a.we));
                    if (e_a.we) begin
                        lm = {{8{e_a.be[3]}}, {8{e_a.be[2]}}, {8{e_a.be[1]}}, {8{e_a.be[0]}}};
                        chk("acc_wdata", cur_a.wdata & lm, e_a.wdata & lm);
                    end
                end
            end
            pend = bus.mem_req && !bus.mem_ack;
            prev_a = cur_a;
            if (bus.rsp_valid) begin
                rsp_count++;
                last_rdata = bus.rsp_rdata;
                last_err = bus.rsp_err;
                last_lat = cyc - accept_cyc + 1;
                if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(exp_rsp.size()), 32'h1);
                else begin
                    e_r = exp_rsp.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e_r.rdata);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e_r.err));
                    chk("rsp_lat", 32'(last_lat), 32'(e_r.lat));
                end
                busy = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                busy = 1'b1;
                accept_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int d, input bit hold);
        int n0, t;
        t = 0;
        while (!bus.req_ready && t < 50) begin step(); t++; end
        ack_delay = d;
        acc_log.delete();
        push_expect(we, f3, addr, wd, d);
        n0 = rsp_count;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        step();
        if (!hold) bus.req_valid = 1'b0;
        t = 0;
        while (rsp_count == n0 && t < 60) begin step(); t++; end
        bus.req_valid = 1'b0;
        chk("rsp_seen", 32'(rsp_count - n0), 32'h1);
    endtask

    op_t ops [8];

    initial begin
        for (int i = 0; i < int'(NWORD); i++)
            for (int l = 0; l < 4; l++)
                bmem[4*i + l] = 8'(((32'(i) * 32'h01010101) ^ 32'h5A5A0000) >> (8*l));
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        step(); step();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        rst_n = 1'b1;
        step();

        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1'b0);
        chk("sw_nacc", 32'(acc_log.size()), 32'd1);
        chk("sw_addr", 32'(acc_log[0].addr), 32'h40);
        chk("sw_be", 32'(acc_log[0].be), 32'hF);
        chk("sw_wdata", acc_log[0].wdata, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        chk("lw_be", 32'(acc_log[0].be), 32'hF);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_lat", 32'(last_lat), 32'd3);

        issue(1'b1, 3'b000, 32'h203, 32'h00000080, 0, 1'b0);
        chk("sb_be", 32'(acc_log[0].be), 32'h8);
        chk("sb_wdata", 32'(acc_log[0].wdata[31:24]), 32'h80);
        issue(1'b0, 3'b000, 32'h203, 32'h0, 0, 1'b0);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h203, 32'h0, 0, 1'b0);
        chk("lbu_rdata", last_rdata, 32'h00000080);

        issue(1'b1, 3'b010, 32'h102, 32'h11223344, 0, 1'b0);
        chk("swx_nacc", 32'(acc_log.size()), 32'd2);
        chk("swx0_addr", 32'(acc_log[0].addr), 32'h40);
        chk("swx0_be", 32'(acc_log[0].be), 32'hC);
        chk("swx0_wd", 32'(acc_log[0].wdata[31:16]), 32'h3344);
        chk("swx1_addr", 32'(acc_log[1].addr), 32'h41);
        chk("swx1_be", 32'(acc_log[1].be), 32'h3);
        chk("swx1_wd", 32'(acc_log[1].wdata[15:0]), 32'h1122);
        chk("swx_lat", 32'(last_lat), 32'd4);
        issue(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b0);
        chk("lwx_rdata", last_rdata, 32'h11223344);

        issue(1'b1, 3'b000, 32'h3FFF, 32'h34, 0, 1'b0);
        issue(1'b1, 3'b000, 32'h0000, 32'h92, 0, 1'b0);
        issue(1'b0, 3'b001, 32'h3FFF, 32'h0, 0, 1'b0);
        chk("lhw_addr0", 32'(acc_log[0].addr), 32'hFFF);
        chk("lhw_addr1", 32'(acc_log[1].addr), 32'h000);
        chk("lhw_rdata", last_rdata, 32'hFFFF9234);
        issue(1'b0, 3'b101, 32'h3FFF, 32'h0, 0, 1'b0);
        chk("lhuw_rdata", last_rdata, 32'h00009234);

        issue(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0);
        chk("ill_err", 32'(last_err), 32'h1);
        chk("ill_lat", 32'(last_lat), 32'd2);
        chk("ill_nacc", 32'(acc_log.size()), 32'd0);
        issue(1'b1, 3'b100, 32'h104, 32'h55, 0, 1'b0);
        chk("ill_sbu_err", 32'(last_err), 32'h1);
        chk("ill_sbu_nacc", 32'(acc_log.size()), 32'd0);
        issue(1'b0, 3'b110, 32'h104, 32'h0, 0, 1'b0);
        issue(1'b1, 3'b111, 32'h104, 32'h0, 0, 1'b0);

        ops[0] = '{1'b1, 3'b001, 32'h205, 32'h0000BEEF};
        ops[1] = '{1'b0, 3'b001, 32'h205, 32'h0};
        ops[2] = '{1'b0, 3'b101, 32'h205, 32'h0};
        ops[3] = '{1'b1, 3'b001, 32'h207, 32'h0000CAFE};
        ops[4] = '{1'b0, 3'b010, 32'h205, 32'h0};
        ops[5] = '{1'b0, 3'b010, 32'h001, 32'h0};
        ops[6] = '{1'b1, 3'b010, 32'h3FFD, 32'hA1B2C3D4};
        ops[7] = '{1'b0, 3'b000, 32'h3FFE, 32'h0};
        foreach (ops[i]) issue(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, i % 3, 1'b0);
        issue(1'b0, 3'b010, 32'h3FFD, 32'h0, 1, 1'b0);
        chk("lwwrap_rdata", last_rdata, 32'hA1B2C3D4);

        issue(1'b0, 3'b010, 32'h102, 32'h0, 3, 1'b1);
        chk("hold_rdata", last_rdata, 32'h11223344);
        chk("hold_lat", 32'(last_lat), 32'd10);

        // Abandon a crossing load once it has moved to its second word.
        begin
            int t, n0;
            ack_delay = 3;
            acc_log.delete();
            push_expect(1'b0, 3'b010, 32'h106, 32'h0, 3);
            void'(exp_rsp.pop_back());
            void'(exp_acc.pop_back());
            n0 = rsp_count;
            bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
            bus.req_addr = 32'h106;
            step();
            bus.req_valid = 1'b0;
            t = 0;
            while (!(bus.mem_req && bus.mem_addr == 12'h042) && t < 40) begin step(); t++; end
            chk("rst_acc1_addr", 32'(bus.mem_addr), 32'h42);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_mem_req", 32'(bus.mem_req), 32'h0);
            chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
            chk("rst_mid_rsp", 32'(bus.rsp_valid), 32'h0);
            step(); step();
            rst_n = 1'b1;
            repeat (6) step();
            chk("rst_no_rsp", 32'(rsp_count), 32'(n0));
            chk("rst_acc_left", 32'(exp_acc.size()), 32'h0);
            chk("rst_idle_ready", 32'(bus.req_ready), 32'h1);
            ack_delay = 0;
        end
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        chk("post_rst_rdata", last_rdata, 32'h3344BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
